// File: rtl/ir_pkg.sv
// Instruction field layout for MIPS words, shared by the fetch queue and the control unit.
package ir_pkg;
   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_MSB = 10;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int J_MSB     = 25;
   localparam int J_LSB     = 0;

   localparam int OPC_W   = 6;
   localparam int REG_W   = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int J_W     = 26;
   localparam int INS_W   = 32;
endpackage

// File: rtl/ins_fifo.sv
// Prefetch storage ring: DEPTH entries, wrap-around pointers, occupancy count.
// Per-entry PC storage exists only when IR_PC_EN is defined.
module ins_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_ins,
   input  logic [PC_W-1:0]   wr_pc,
   output logic              in_ready,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] head_ins,
   output logic [PC_W-1:0]   head_pc
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_ins [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   assign in_ready = (count < CNT_W'(DEPTH));
   assign do_push  = push && in_ready && !flush;
   // Pop only looks at registered occupancy, so a word never bypasses the queue.
   assign do_pop   = pop && (count != '0) && !flush;
   assign head_ins = mem_ins[rd_ptr];

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (do_push) mem_ins[wr_ptr] <= wr_ins;
   end

`ifdef IR_PC_EN
   logic [PC_W-1:0] mem_pc [DEPTH];

   always_ff @(negedge clk) begin
      if (do_push) mem_pc[wr_ptr] <= wr_pc;
   end

   assign head_pc = mem_pc[rd_ptr];
`else
   logic unused_wr_pc;

   assign unused_wr_pc = ^wr_pc;
   assign head_pc      = '0;
`endif
endmodule

// File: rtl/ins_fetch_queue.sv
// Prefetch queue plus decoded instruction-register stage with stall and flush.
// Define IR_PC_EN to track the PC of each instruction through to out_pc.
module ins_fetch_queue
   import ir_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_ins,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               IRWre,
   input  logic               Flush,
   output logic               out_valid,
   output logic [OPC_W-1:0]   Opcode,
   output logic [REG_W-1:0]   rs,
   output logic [REG_W-1:0]   rt,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   shamt,
   output logic [FUNCT_W-1:0] funct,
   output logic [IMM_W-1:0]   immediate,
   output logic [J_W-1:0]     bits_26,
   output logic [PC_W-1:0]    out_pc
);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] head_ins;
   logic [PC_W-1:0]   head_pc;
   logic [INS_W-1:0]  ir_q;
   logic              load;

   ins_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) u_fifo (
      .clk      (CLK),
      .rst      (Reset),
      .flush    (Flush),
      .push     (in_valid),
      .pop      (IRWre),
      .wr_ins   (in_ins),
      .wr_pc    (in_pc),
      .in_ready (in_ready),
      .count    (count),
      .head_ins (head_ins),
      .head_pc  (head_pc)
   );

   assign load = IRWre && (count != '0);

   // Flush beats stall; an advance with nothing queued drops valid but keeps the fields.
   always_ff @(negedge CLK or posedge Reset) begin
      if (Reset) begin
         ir_q      <= '0;
         out_valid <= 1'b0;
      end else if (Flush) begin
         ir_q      <= '0;
         out_valid <= 1'b0;
      end else if (IRWre) begin
         out_valid <= load;
         if (load) ir_q <= head_ins[INS_W-1:0];
      end
   end

   assign Opcode    = ir_q[OPC_MSB:OPC_LSB];
   assign rs        = ir_q[RS_MSB:RS_LSB];
   assign rt        = ir_q[RT_MSB:RT_LSB];
   assign rd        = ir_q[RD_MSB:RD_LSB];
   assign shamt     = ir_q[SHAMT_MSB:SHAMT_LSB];
   assign funct     = ir_q[FUNCT_MSB:FUNCT_LSB];
   assign immediate = ir_q[IMM_MSB:IMM_LSB];
   assign bits_26   = ir_q[J_MSB:J_LSB];

   if (DATA_W > INS_W) begin : g_wide
      logic unused_hi;
      assign unused_hi = ^head_ins[DATA_W-1:INS_W];
   end

`ifdef IR_PC_EN
   logic [PC_W-1:0] pc_q;

   always_ff @(negedge CLK or posedge Reset) begin
      if (Reset)      pc_q <= '0;
      else if (Flush) pc_q <= '0;
      else if (load)  pc_q <= head_pc;
   end

   assign out_pc = pc_q;
`else
   logic unused_head_pc;

   assign unused_head_pc = ^head_pc;
   assign out_pc         = '0;
`endif
endmodule
